// File: rtl/imm_encoder.sv
// Packs a signed immediate plus register fields into a LEGv8 LDUR/STUR/CBZ word.
// Two-stage valid/ready pipeline with range checking and saturating result counters.
module imm_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       kind,
  input  logic [4:0]       rt,
  input  logic [4:0]       rn,
  input  logic [63:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    KIND_LDUR = 2'd0,
    KIND_STUR = 2'd1,
    KIND_CBZ  = 2'd2,
    KIND_RSVD = 2'd3
  } kind_e;

  logic             r_s1Valid;
  kind_e            r_s1Kind;
  logic [4:0]       r_s1Rt;
  logic [4:0]       r_s1Rn;
  logic [18:0]      r_s1Imm;
  logic             r_s1Ok;

  logic             r_s2Valid;
  logic [31:0]      r_instr;
  logic             r_err;
  logic [CNT_W-1:0] r_encCount;
  logic [CNT_W-1:0] r_errCount;

  logic             w_s2Adv;
  logic             w_s1Adv;
  logic             w_accept;
  logic             w_consume;
  logic             w_fits9;
  logic             w_fits19;
  logic             w_rangeOk;
  logic [31:0]      w_packed;

  assign w_s2Adv   = ~r_s2Valid | out_ready;
  assign w_s1Adv   = r_s1Valid & w_s2Adv;
  assign in_ready  = ~r_s1Valid | w_s2Adv;
  assign w_accept  = in_valid & in_ready;
  assign w_consume = r_s2Valid & out_ready;

  // An immediate fits its field when every bit above the field's sign bit matches it.
  assign w_fits9  = (&imm[63:8])  | ~(|imm[63:8]);
  assign w_fits19 = (&imm[63:18]) | ~(|imm[63:18]);

  always_comb begin
    w_rangeOk = 1'b0;
    case (kind_e'(kind))
      KIND_LDUR, KIND_STUR: w_rangeOk = w_fits9;
      KIND_CBZ:             w_rangeOk = w_fits19;
      default:              w_rangeOk = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1Valid <= 1'b0;
      r_s1Kind  <= KIND_LDUR;
      r_s1Rt    <= '0;
      r_s1Rn    <= '0;
      r_s1Imm   <= '0;
      r_s1Ok    <= 1'b0;
    end else if (w_accept) begin
      r_s1Valid <= 1'b1;
      r_s1Kind  <= kind_e'(kind);
      r_s1Rt    <= rt;
      r_s1Rn    <= rn;
      r_s1Imm   <= imm[18:0];
      r_s1Ok    <= w_rangeOk;
    end else if (w_s1Adv) begin
      r_s1Valid <= 1'b0;
    end
  end

  // Errored words are emitted as all-zero so the loader never writes a bogus opcode.
  always_comb begin
    w_packed = 32'h0000_0000;
    if (r_s1Ok) begin
      case (r_s1Kind)
        KIND_LDUR: w_packed = {11'b11111000010, r_s1Imm[8:0], 2'b00, r_s1Rn, r_s1Rt};
        KIND_STUR: w_packed = {11'b11111000000, r_s1Imm[8:0], 2'b00, r_s1Rn, r_s1Rt};
        KIND_CBZ:  w_packed = {8'b10110100, r_s1Imm, r_s1Rt};
        default:   w_packed = 32'h0000_0000;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s2Valid <= 1'b0;
      r_instr   <= '0;
      r_err     <= 1'b0;
    end else if (w_s2Adv) begin
      r_s2Valid <= r_s1Valid;
      if (r_s1Valid) begin
        r_instr <= w_packed;
        r_err   <= ~r_s1Ok;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_encCount <= '0;
      r_errCount <= '0;
    end else if (w_consume) begin
      if (r_err) begin
        if (!(&r_errCount)) r_errCount <= r_errCount + 1'b1;
      end else begin
        if (!(&r_encCount)) r_encCount <= r_encCount + 1'b1;
      end
    end
  end

  assign out_valid = r_s2Valid;
  assign instr     = r_instr;
  assign out_err   = r_err;
  assign enc_count = r_encCount;
  assign err_count = r_errCount;

endmodule
